// File: rtl/uart_send_pkg.sv
// ============================================================================
// Module      : uart_send_pkg
// Description : Shared types and constants for the UART send buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_send_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_GUARD  = 2'd2
  } state_t;

  typedef logic [1:0] byte_idx_t;

endpackage

`default_nettype wire

// File: rtl/sync_word_fifo.sv
// ============================================================================
// Module      : sync_word_fifo
// Description : Synchronous word FIFO with combinational head and occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_word_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] c_depth = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_push;
  logic                  w_pop;

  // A pop frees its slot in the same cycle, so a push into a full FIFO is legal then.
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  assign dout  = r_mem[r_rd_ptr];
  assign count = r_count;
  assign full  = (r_count == c_depth);
  assign empty = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/uart_send_buffer.sv
// ============================================================================
// Module      : uart_send_buffer
// Description : Buffers 32-bit send words and feeds them bytewise to UART tx.
//               UART_SEND_BIG_ENDIAN_EN selects MSB-first byte order.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_send_buffer
  import uart_send_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  send_en,
  input  logic [31:0]           send_content,
  output logic                  send_busy,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  input  logic                  tx_busy,
  output logic                  overflow,
  output logic [DEPTH_LOG2:0]   words_pending
);

  localparam logic [DEPTH_LOG2:0] c_busy_level = {1'b0, {DEPTH_LOG2{1'b1}}};
  localparam byte_idx_t           c_last_idx   = byte_idx_t'(BYTES_PER_WORD - 1);

  state_t              r_state;
  byte_idx_t           r_idx;
  logic [31:0]         r_word;
  logic [7:0]          r_tx_data;
  logic                r_overflow;
  logic [31:0]         w_head;
  logic [DEPTH_LOG2:0] w_count;
  logic                w_full;
  logic                w_empty;
  logic                w_launch;
  logic                w_pop;
  logic                w_drop;
  byte_idx_t           w_next_idx;

  function automatic logic [7:0] pick_byte(input logic [31:0] word, input byte_idx_t idx);
    byte_idx_t lane;
`ifdef UART_SEND_BIG_ENDIAN_EN
    lane = ~idx;
`else
    lane = idx;
`endif
    return word[{lane, 3'b000} +: 8];
  endfunction

  sync_word_fifo #(
    .WIDTH      (32),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (send_en),
    .pop   (w_pop),
    .din   (send_content),
    .dout  (w_head),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  // Launch gates on the live tx_busy so a byte goes out the first cycle the UART frees up.
  assign w_launch   = (r_state == S_LAUNCH) && !tx_busy;
  assign w_pop      = w_launch && (r_idx == c_last_idx);
  assign w_drop     = send_en && w_full && !w_pop;
  assign w_next_idx = r_idx + 2'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_word     <= '0;
      r_tx_data  <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_drop) r_overflow <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_word    <= w_head;
            r_idx     <= '0;
            r_tx_data <= pick_byte(w_head, 2'd0);
            r_state   <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          if (!tx_busy) r_state <= S_GUARD;
        end
        S_GUARD: begin
          if (r_idx != c_last_idx) begin
            r_idx     <= w_next_idx;
            r_tx_data <= pick_byte(r_word, w_next_idx);
            r_state   <= S_LAUNCH;
          end else if (!w_empty) begin
            r_word    <= w_head;
            r_idx     <= '0;
            r_tx_data <= pick_byte(w_head, 2'd0);
            r_state   <= S_LAUNCH;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign send_busy     = (w_count >= c_busy_level);
  assign tx_start      = w_launch;
  assign tx_data       = r_tx_data;
  assign overflow      = r_overflow;
  assign words_pending = w_count;

endmodule

`default_nettype wire
